// File: rtl/btn_event_if.sv
// rtl/btn_event_if.sv - event FIFO head and valid/ack handshake between btn_event and its consumer
interface btn_event_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ack;
  logic [2:0] evt_cnt;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_cnt,
    input  evt_ack
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_cnt,
    output evt_ack
  );
endinterface

// File: rtl/btn_event.sv
// rtl/btn_event.sv - SHORT/LONG/REPEAT press events from a debounced button, queued in a 4-entry FIFO
// REPEAT generation is compiled in only when BTN_EVENT_REPEAT_EN is defined.
module btn_event #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ena,
  input  logic        btn_in,
  input  logic [7:0]  long_time,
  input  logic [7:0]  rep_time,
  btn_event_if.master evt,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic        pressed
);

  localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
  localparam logic [1:0] CODE_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic          btn_q;
  logic          press_edge;
  logic          release_edge;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [7:0]    hold_cnt;

  logic          push;
  logic [1:0]    push_code;
  logic          enter_long;
  logic          rep_fire;

  logic [1:0]    fifo_mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    cnt;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;

  always_ff @(posedge clk) begin
    if (res) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_in;
    end
  end

  assign pressed      = btn_q;
  assign press_edge   = btn_in & ~btn_q;
  assign release_edge = ~btn_in & btn_q;
  assign tick         = (presc_q == PRE_LAST);

  // Restarting the ms phase on LONG entry and after each REPEAT makes every
  // threshold land exactly N*PRESCALE+1 cycles after the event that armed it.
  always_ff @(posedge clk) begin
    if (res || !ena) begin
      presc_q  <= '0;
      hold_cnt <= 8'd0;
    end else begin
      if (press_edge || enter_long || rep_fire || tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      if (press_edge) begin
        hold_cnt <= 8'd0;
      end else if (state_q == ST_HELD && tick && hold_cnt != 8'hff) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

`ifdef BTN_EVENT_REPEAT_EN
  logic [7:0] rep_cnt;

  always_ff @(posedge clk) begin
    if (res || !ena) begin
      rep_cnt <= 8'd0;
    end else if (enter_long || rep_fire) begin
      rep_cnt <= 8'd0;
    end else if (state_q == ST_LONG && tick && rep_cnt != 8'hff) begin
      rep_cnt <= rep_cnt + 8'd1;
    end
  end
`else
  logic unused_rep_time;
  assign unused_rep_time = ^rep_time;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Release is checked before any threshold so a coincident match never wins.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_code  = 2'b00;
    enter_long = 1'b0;
    rep_fire   = 1'b0;
    if (!ena) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press_edge) begin
            state_d = ST_HELD;
          end
        end
        ST_HELD: begin
          if (release_edge) begin
            state_d   = ST_IDLE;
            push      = 1'b1;
            push_code = CODE_SHORT;
          end else if (long_time != 8'd0 && hold_cnt == long_time) begin
            state_d    = ST_LONG;
            push       = 1'b1;
            push_code  = CODE_LONG;
            enter_long = 1'b1;
          end
        end
        ST_LONG: begin
          if (release_edge) begin
            state_d = ST_IDLE;
          end
`ifdef BTN_EVENT_REPEAT_EN
          else if (rep_time != 8'd0 && rep_cnt == rep_time) begin
            push      = 1'b1;
            push_code = CODE_REPEAT;
            rep_fire  = 1'b1;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign full    = (cnt == 3'd4);
  assign pop     = evt.evt_ack && (cnt != 3'd0);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      cnt      <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      cnt <= cnt + {2'b00, do_push} - {2'b00, pop};
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = (cnt != 3'd0);
  assign evt.evt_cnt   = cnt;
  assign evt.evt_code  = (cnt != 3'd0) ? fifo_mem[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_btn_event.sv
// tb/tb_btn_event.sv - randomized scoreboard bench for btn_event against a press-timeline model
module tb_btn_event;

  localparam int P = 10;
`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res;
  logic       ena;
  logic       btn_in;
  logic [7:0] long_time;
  logic [7:0] rep_time;
  logic       overflow;
  logic       ovf_clr;
  logic       pressed;

  btn_event_if evt_if ();

  btn_event #(.PRESCALE(P)) dut (
    .clk       (clk),
    .res       (res),
    .ena       (ena),
    .btn_in    (btn_in),
    .long_time (long_time),
    .rep_time  (rep_time),
    .evt       (evt_if.master),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .pressed   (pressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [1:0] code;
  } sched_t;

  sched_t     pend[$];
  logic [1:0] mfifo[$];
  bit         m_ovf = 1'b0;
  bit         exp_pressed = 1'b0;
  bit         started = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         ack_force = 1'b0;
  bit         ack_rand = 1'b0;
  int         ack_pct = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  // Event timeline of one press, from the press-edge cycle e0 and hold length d.
  task automatic plan_press(input int e0, input int d);
    sched_t s;
    int     lt;
    int     rt;
    int     t;
    lt = int'(long_time);
    rt = int'(rep_time);
    if (lt != 0 && d > lt * P + 1) begin
      s.t = e0 + lt * P + 1;
      s.code = 2'b10;
      pend.push_back(s);
      if (REP_EN && rt != 0) begin
        t = s.t + rt * P + 1;
        while (t < e0 + d) begin
          s.t = t;
          s.code = 2'b11;
          pend.push_back(s);
          t += rt * P + 1;
        end
      end
    end else begin
      s.t = e0 + d;
      s.code = 2'b01;
      pend.push_back(s);
    end
  endtask

  task automatic press(input int d, input int gap, input bit ack_rel, input bit clr_rel);
    btn_in = 1'b1;
    plan_press(cyc + 1, d);
    repeat (d) @(posedge clk);
    #1;
    btn_in = 1'b0;
    if (ack_rel) ack_force = 1'b1;
    if (clr_rel) ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ack_force = 1'b0;
    ovf_clr = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    ack_rand = 1'b1;
    ack_pct = 100;
    while ((mfifo.size() != 0 || evt_if.evt_valid) && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_done", int'(k < 40), 1);
    ack_rand = 1'b0;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  // Behavioural FIFO/overflow model advanced at each active edge.
  initial begin : model
    bit pop;
    bit drop;
    forever begin
      @(posedge clk);
      cyc++;
      if (res) begin
        mfifo.delete();
        pend.delete();
        m_ovf = 1'b0;
        exp_pressed = 1'b0;
        started = 1'b1;
      end else begin
        exp_pressed = btn_in;
        pop = (mfifo.size() > 0) && evt_if.evt_ack;
        if (pop) void'(mfifo.pop_front());
        drop = 1'b0;
        while (pend.size() > 0 && pend[0].t <= cyc) begin
          if (mfifo.size() < 4) mfifo.push_back(pend[0].code);
          else drop = 1'b1;
          void'(pend.pop_front());
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (started) begin
        chk("evt_valid", int'(evt_if.evt_valid), int'(mfifo.size() != 0));
        chk("evt_cnt", int'(evt_if.evt_cnt), mfifo.size());
        chk("evt_code", int'(evt_if.evt_code), (mfifo.size() != 0) ? int'(mfifo[0]) : 0);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("pressed", int'(pressed), int'(exp_pressed));
      end
    end
  end

  initial begin : ack_gen
    evt_if.evt_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      evt_if.evt_ack = ack_force || (ack_rand && ($urandom_range(0, 99) < ack_pct));
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : stim
    res = 1'b1;
    ena = 1'b1;
    btn_in = 1'b0;
    ovf_clr = 1'b0;
    long_time = 8'd5;
    rep_time = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;

    press(30, 5, 1'b0, 1'b0);
    drain();
    press(200, 5, 1'b0, 1'b0);
    drain();
    rep_time = 8'd2;
    press(120, 5, 1'b0, 1'b0);
    drain();

    // Threshold boundary: release on the match cycle versus one cycle later.
    rep_time = 8'd0;
    press(51, 3, 1'b0, 1'b0);
    press(52, 3, 1'b0, 1'b0);
    drain();
    long_time = 8'd0;
    press(300, 3, 1'b0, 1'b0);
    drain();
    long_time = 8'd5;

    for (int i = 0; i < 5; i++) press(12, 3, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    drain();
    pulse_clr();

    for (int i = 0; i < 4; i++) press(12, 2, 1'b0, 1'b0);
    press(15, 2, 1'b1, 1'b0);
    press(15, 2, 1'b0, 1'b1);
    drain();
    pulse_clr();

    // Held across enable rising: no event until a fresh press.
    ena = 1'b0;
    btn_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    ena = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    btn_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ena = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    press(20, 3, 1'b0, 1'b0);
    drain();

    press(12, 2, 1'b0, 1'b0);
    press(12, 2, 1'b0, 1'b0);
    btn_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    press(80, 3, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: long_time = 8'd0;
        1: long_time = 8'd1;
        2: long_time = 8'd2;
        3: long_time = 8'd3;
        default: long_time = 8'd5;
      endcase
      rep_time = 8'($urandom_range(0, 3));
      ack_rand = 1'b1;
      ack_pct = $urandom_range(0, 100);
      press($urandom_range(1, 130), $urandom_range(0, 15),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    drain();

    chk("pending_empty", pend.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
